hedios_action_scheduler: RTL and testbench

Round-robin scheduler that drains pending action flags from the Hedios action handler into a single shared action executor, one action at a time. It sits between the handler's latched action outputs and the executor. For each served action it performs a valid/ready command handshake, waits for completion or timeout, then pulses the matching device-clear line back to the handler.

---
 rtl/hedios_action_scheduler_pkg.sv | 19 +
 rtl/hedios_action_scheduler_if.sv | 26 ++
 rtl/hedios_rr_picker.sv | 31 +++
 rtl/hedios_action_scheduler.sv | 113 +++++++++++
 tb/tb_hedios_action_scheduler.sv | 490 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hedios_action_scheduler_pkg.sv
// Shared types for the Hedios action scheduler.
// FSM state encoding and the id-width helper.
package hedios_sched_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE,
        S_ISSUE,
        S_EXEC,
        S_ACK,
        S_SETTLE
    } state_e;

    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hedios_action_scheduler_if.sv
// Command channel between the scheduler and the shared action executor.
// The scheduler is the master; the executor is the slave.
interface hedios_action_scheduler_if #(
    parameter int ID_W = 3
) ();

    logic            cmd_valid;
    logic            cmd_ready;
    logic [ID_W-1:0] cmd_id;
    logic            done;

    modport master (
        output cmd_valid,
        output cmd_id,
        input  cmd_ready,
        input  done
    );

    modport slave (
        input  cmd_valid,
        input  cmd_id,
        output cmd_ready,
        output done
    );

endinterface

// File: rtl/hedios_rr_picker.sv
// Combinational round-robin picker.
// Searches upward from last_i+1 with wrap; first set request wins.
module hedios_rr_picker
    import hedios_sched_pkg::*;
#(
    parameter int ACTION_COUNT = 8
) (
    input  logic [ACTION_COUNT-1:0]         req_i,
    input  logic [id_w(ACTION_COUNT)-1:0]   last_i,
    output logic                            found_o,
    output logic [id_w(ACTION_COUNT)-1:0]   sel_o
);

    localparam int ID_W = id_w(ACTION_COUNT);

    logic [ID_W-1:0] cand;

    always_comb begin
        found_o = 1'b0;
        sel_o   = '0;
        cand    = '0;
        for (int i = 1; i <= ACTION_COUNT; i++) begin
            cand = ID_W'((int'(last_i) + i) % ACTION_COUNT);
            if (!found_o && req_i[cand]) begin
                found_o = 1'b1;
                sel_o   = cand;
            end
        end
    end

endmodule

// File: rtl/hedios_action_scheduler.sv
// Round-robin scheduler draining handler action flags into one executor.
// Holds the service FSM, timeout counter, sticky error and ack register.
module hedios_action_scheduler
    import hedios_sched_pkg::*;
#(
    parameter int ACTION_COUNT = 8,
    parameter int TIMEOUT      = 1024,
    parameter int ID_W         = id_w(ACTION_COUNT)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic [ACTION_COUNT-1:0] pending,
    output logic [ACTION_COUNT-1:0] ack,
    hedios_action_scheduler_if.master cmd,
    output logic                    busy,
    output logic                    timeout_err,
    input  logic                    err_clr
);

    localparam int CNT_W = id_w(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST =
        (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    state_e                  state_q, state_d;
    logic [ID_W-1:0]         id_q, id_d;
    logic [ID_W-1:0]         last_q, last_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    err_q, err_d;
    logic [ACTION_COUNT-1:0] ack_q, ack_d;

    logic                    found;
    logic [ID_W-1:0]         sel;
    logic                    to_hit;

    hedios_rr_picker #(
        .ACTION_COUNT(ACTION_COUNT)
    ) u_picker (
        .req_i   (pending),
        .last_i  (last_q),
        .found_o (found),
        .sel_o   (sel)
    );

    assign to_hit = (TIMEOUT > 0) && (cnt_q >= CNT_LAST);

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        ack_d   = '0;
        if ((state_q == S_ISSUE || state_q == S_EXEC) && cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        unique case (state_q)
            S_IDLE: begin
                if (enable && found) begin
                    state_d = S_ISSUE;
                    id_d    = sel;
                    cnt_d   = '0;
                end
            end
            S_ISSUE: begin
                if (cmd.cmd_ready) state_d = S_EXEC;
            end
            S_EXEC: begin
                // done beats a same-cycle timeout
                if (cmd.done) begin
                    state_d   = S_ACK;
                    ack_d[id_q] = 1'b1;
                end else if (to_hit) begin
                    state_d   = S_ACK;
                    ack_d[id_q] = 1'b1;
                    err_d     = 1'b1;
                end
            end
            S_ACK: begin
                last_d  = id_q;
                state_d = S_SETTLE;
            end
            S_SETTLE: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        if (err_clr) err_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            id_q    <= '0;
            last_q  <= ID_W'(ACTION_COUNT - 1);
            cnt_q   <= '0;
            err_q   <= 1'b0;
            ack_q   <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            ack_q   <= ack_d;
        end
    end

    assign cmd.cmd_valid = (state_q == S_ISSUE);
    assign cmd.cmd_id    = id_q;
    assign busy          = (state_q != S_IDLE);
    assign ack           = ack_q;
    assign timeout_err   = err_q;

endmodule

// File: tb/tb_hedios_action_scheduler.sv
// Bench for hedios_action_scheduler: directed scenarios plus random
// services, checked against a round-robin reference model.
module tb_hedios_action_scheduler;

    localparam int N  = 8;
    localparam int TO = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         enable = 1'b0;
    logic         err_clr = 1'b0;
    logic [N-1:0] pending = '0;
    logic [N-1:0] ack;
    logic         busy;
    logic         timeout_err;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int model_last = N - 1;

    hedios_action_scheduler_if #(.ID_W(3)) ifc ();

    hedios_action_scheduler #(
        .ACTION_COUNT(N),
        .TIMEOUT(TO),
        .ID_W(3)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .pending     (pending),
        .ack         (ack),
        .cmd         (ifc),
        .busy        (busy),
        .timeout_err (timeout_err),
        .err_clr     (err_clr)
    );

    always #5 clk = ~clk;

    // Reference: next index searched upward from last+1 with wrap.
    function automatic int rr_next(input logic [N-1:0] p, input int last);
        for (int k = 1; k <= N; k++) begin
            int j;
            j = (last + k) % N;
            if (p[j[2:0]]) return j;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] v;
        v = '0;
        v[i[2:0]] = 1'b1;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        enable = 1'b0;
        err_clr = 1'b0;
        pending = '0;
        ifc.cmd_ready = 1'b0;
        ifc.done = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        model_last = N - 1;
    endtask

    // Drives one service; handler clears the acked bit, ORs in raise.
    // lat = cycles from handshake to ack; ddly<0 means no done.
    task automatic run_service(
        input  int           rdly,
        input  int           ddly,
        input  logic [N-1:0] raise,
        output int           id,
        output logic [N-1:0] ackv,
        output int           lat,
        output int           vc,
        output bit           to
    );
        int n;
        to = 1'b0;
        id = -1;
        ackv = '0;
        lat = 0;
        vc = 0;
        n = 0;
        while (ifc.cmd_valid !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        if (n >= 40) begin
            to = 1'b1;
            return;
        end
        vc = cyc;
        id = int'(ifc.cmd_id);
        repeat (rdly) step();
        ifc.cmd_ready = 1'b1;
        step();
        ifc.cmd_ready = 1'b0;
        n = 0;
        while (ack === '0 && n < 64) begin
            ifc.done = (n == ddly);
            step();
            ifc.done = 1'b0;
            n++;
        end
        if (n >= 64) begin
            to = 1'b1;
            return;
        end
        lat = n + 1;
        ackv = ack;
        pending = (pending & ~ackv) | raise;
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        ifc.cmd_ready = 1'b0;
        ifc.done = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        vectors++;
        if ({ifc.cmd_valid, ifc.cmd_id, ack, busy, timeout_err} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got v=%b id=%0d ack=%b busy=%b err=%b required all 0",
                     ifc.cmd_valid, ifc.cmd_id, ack, busy, timeout_err);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        model_last = N - 1;
        step();
        vectors++;
        if (busy !== 1'b0 || ifc.cmd_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle: got busy=%b valid=%b required 0 0", busy, ifc.cmd_valid);
        end
    endtask

    task automatic test_single();
        int id, lat, vc, exp;
        logic [N-1:0] a;
        bit to;
        enable = 1'b1;
        pending = 8'b0000_0100;
        exp = rr_next(pending, model_last);
        step();
        vectors++;
        if (ifc.cmd_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL single_latency: got valid=%b required 1", ifc.cmd_valid);
        end
        run_service(0, 0, '0, id, a, lat, vc, to);
        vectors++;
        if (to || id != exp || a !== onehot(exp)) begin
            miscompares++;
            $display("FAIL single_id: got id=%0d ack=%b to=%0d required id=%0d ack=%b",
                     id, a, to, exp, onehot(exp));
        end
        vectors++;
        if (lat != 2 || ack !== '0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL single_settle: got lat=%0d ack=%b busy=%b required 2 0 1",
                     lat, ack, busy);
        end
        step();
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL single_busy_drop: got busy=%b required 0", busy);
        end
        model_last = exp;
    endtask

    task automatic test_fairness();
        int id, lat, vc, exp, prev_vc;
        logic [N-1:0] a;
        bit to;
        do_reset();
        enable = 1'b1;
        pending = 8'hFF;
        prev_vc = 0;
        for (int i = 0; i < N; i++) begin
            exp = rr_next(pending, model_last);
            run_service(0, 0, '0, id, a, lat, vc, to);
            vectors++;
            if (to || id != exp || a !== onehot(exp)) begin
                miscompares++;
                $display("FAIL fair_order[%0d]: got id=%0d ack=%b required id=%0d",
                         i, id, a, exp);
            end
            if (i > 0) begin
                vectors++;
                if (vc - prev_vc != 5) begin
                    miscompares++;
                    $display("FAIL fair_throughput[%0d]: got %0d cycles required 5",
                             i, vc - prev_vc);
                end
            end
            prev_vc = vc;
            model_last = exp;
        end
        // last_served moves to 1, so a raise of 3 and 0 serves 3 first
        pending = 8'h02;
        exp = rr_next(pending, model_last);
        run_service(0, 0, '0, id, a, lat, vc, to);
        model_last = exp;
        pending = 8'h09;
        for (int i = 0; i < 2; i++) begin
            exp = rr_next(pending, model_last);
            run_service(1, 1, '0, id, a, lat, vc, to);
            vectors++;
            if (to || id != exp || a !== onehot(exp)) begin
                miscompares++;
                $display("FAIL fair_reraise[%0d]: got id=%0d required %0d", i, id, exp);
            end
            model_last = exp;
        end
    endtask

    task automatic test_backpressure();
        int id, lat, vc, exp, n;
        logic [N-1:0] a;
        logic [2:0] id0;
        bit to, stable;
        pending = 8'h40;
        exp = rr_next(pending, model_last);
        n = 0;
        while (ifc.cmd_valid !== 1'b1 && n < 10) begin
            step();
            n++;
        end
        id0 = ifc.cmd_id;
        vectors++;
        if (ifc.cmd_valid !== 1'b1 || id0 !== 3'(exp)) begin
            miscompares++;
            $display("FAIL bp_offer: got valid=%b id=%0d required 1 %0d",
                     ifc.cmd_valid, id0, exp);
        end
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            ifc.done = (i == 5);
            if (ifc.cmd_valid !== 1'b1 || ifc.cmd_id !== id0) stable = 1'b0;
            step();
        end
        ifc.done = 1'b0;
        vectors++;
        if (!stable) begin
            miscompares++;
            $display("FAIL bp_stable: got unstable valid/id required stable 10 cycles");
        end
        vectors++;
        if (ifc.cmd_valid !== 1'b1 || ack !== '0) begin
            miscompares++;
            $display("FAIL bp_done_ignored: got valid=%b ack=%b required 1 0",
                     ifc.cmd_valid, ack);
        end
        run_service(0, 1, '0, id, a, lat, vc, to);
        vectors++;
        if (to || id != exp || a !== onehot(exp) || lat != 3) begin
            miscompares++;
            $display("FAIL bp_service: got id=%0d ack=%b lat=%0d required %0d %b 3",
                     id, a, lat, exp, onehot(exp));
        end
        model_last = exp;
    endtask

    task automatic test_timeout();
        int id, lat, vc, exp;
        logic [N-1:0] a;
        bit to;
        pending = 8'h08;
        exp = rr_next(pending, model_last);
        run_service(0, -1, '0, id, a, lat, vc, to);
        vectors++;
        if (to || lat != TO || a !== onehot(exp)) begin
            miscompares++;
            $display("FAIL timeout_ack: got lat=%0d ack=%b to=%0d required %0d %b",
                     lat, a, to, TO, onehot(exp));
        end
        vectors++;
        if (timeout_err !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_err_set: got %b required 1", timeout_err);
        end
        model_last = exp;
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        vectors++;
        if (timeout_err !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_err_clr: got %b required 0", timeout_err);
        end
        pending = 8'h08;
        exp = rr_next(pending, model_last);
        run_service(0, TO - 2, '0, id, a, lat, vc, to);
        vectors++;
        if (to || lat != TO || a !== onehot(exp) || timeout_err !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_done_wins: got lat=%0d err=%b required %0d 0",
                     lat, timeout_err, TO);
        end
        model_last = exp;
        pending = 8'h08;
        exp = rr_next(pending, model_last);
        err_clr = 1'b1;
        run_service(0, -1, '0, id, a, lat, vc, to);
        err_clr = 1'b0;
        vectors++;
        if (to || lat != TO || timeout_err !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_clr_priority: got lat=%0d err=%b required %0d 0",
                     lat, timeout_err, TO);
        end
        model_last = exp;
    endtask

    task automatic test_enable();
        int id, lat, vc, exp;
        logic [N-1:0] a;
        bit to, saw;
        enable = 1'b0;
        pending = 8'h11;
        saw = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (ifc.cmd_valid === 1'b1 || busy === 1'b1) saw = 1'b1;
        end
        vectors++;
        if (saw) begin
            miscompares++;
            $display("FAIL enable_low_pick: got a pick required none");
        end
        exp = rr_next(pending, model_last);
        enable = 1'b1;
        step();
        vectors++;
        if (ifc.cmd_valid !== 1'b1 || ifc.cmd_id !== 3'(exp)) begin
            miscompares++;
            $display("FAIL enable_pick: got valid=%b id=%0d required 1 %0d",
                     ifc.cmd_valid, ifc.cmd_id, exp);
        end
        ifc.cmd_ready = 1'b1;
        step();
        ifc.cmd_ready = 1'b0;
        enable = 1'b0;
        step();
        ifc.done = 1'b1;
        step();
        ifc.done = 1'b0;
        vectors++;
        if (ack !== onehot(exp)) begin
            miscompares++;
            $display("FAIL enable_drop_ack: got %b required %b", ack, onehot(exp));
        end
        pending = pending & ~ack;
        model_last = exp;
        saw = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (ifc.cmd_valid === 1'b1) saw = 1'b1;
        end
        vectors++;
        if (saw || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL enable_no_repick: got pick=%0d busy=%b required 0 0", saw, busy);
        end
        enable = 1'b1;
        exp = rr_next(pending, model_last);
        run_service(0, 0, '0, id, a, lat, vc, to);
        vectors++;
        if (to || id != exp || a !== onehot(exp)) begin
            miscompares++;
            $display("FAIL enable_resume: got id=%0d required %0d", id, exp);
        end
        model_last = exp;
    endtask

    task automatic test_async_reset();
        int id, lat, vc, exp, n;
        logic [N-1:0] a;
        bit to;
        pending = 8'h20;
        n = 0;
        while (ifc.cmd_valid !== 1'b1 && n < 10) begin
            step();
            n++;
        end
        ifc.cmd_ready = 1'b1;
        step();
        ifc.cmd_ready = 1'b0;
        step();
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({ifc.cmd_valid, ifc.cmd_id, ack, busy, timeout_err} !== '0) begin
            miscompares++;
            $display("FAIL async_reset_outputs: got id=%0d busy=%b ack=%b required all 0",
                     ifc.cmd_id, busy, ack);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (ack !== '0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset_hold: got ack=%b busy=%b required 0 0", ack, busy);
        end
        rst_n = 1'b1;
        model_last = N - 1;
        exp = rr_next(pending, model_last);
        run_service(0, 0, '0, id, a, lat, vc, to);
        vectors++;
        if (to || id != exp || a !== onehot(exp)) begin
            miscompares++;
            $display("FAIL async_reset_reserve: got id=%0d ack=%b required %0d %b",
                     id, a, exp, onehot(exp));
        end
        model_last = exp;
    endtask

    task automatic test_random();
        int id, lat, vc, exp, rdly, ddly;
        logic [N-1:0] a, raise;
        bit to;
        enable = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (pending == '0 || $urandom_range(0, 1) == 1)
                pending = pending | 8'($urandom_range(1, 255));
            rdly = $urandom_range(0, 3);
            ddly = $urandom_range(0, 5);
            raise = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 255)) : '0;
            exp = rr_next(pending, model_last);
            run_service(rdly, ddly, raise, id, a, lat, vc, to);
            vectors++;
            if (to || id != exp) begin
                miscompares++;
                $display("FAIL rand_id[%0d]: got %0d required %0d", i, id, exp);
            end
            vectors++;
            if (a !== onehot(exp)) begin
                miscompares++;
                $display("FAIL rand_ack[%0d]: got %b required %b", i, a, onehot(exp));
            end
            vectors++;
            if (lat != ddly + 2) begin
                miscompares++;
                $display("FAIL rand_lat[%0d]: got %0d required %0d", i, lat, ddly + 2);
            end
            model_last = exp;
        end
        vectors++;
        if (timeout_err !== 1'b0) begin
            miscompares++;
            $display("FAIL rand_err: got %b required 0", timeout_err);
        end
    endtask

    initial begin
        ifc.cmd_ready = 1'b0;
        ifc.done = 1'b0;
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_timeout();
        test_enable();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion required finish");
        $fatal(1, "watchdog expired");
    end

endmodule
